// File: rtl/ddr1_pkg.sv
// DDR1 host command initiator: shared command encodings, FSM states
// and open-row lookup result.
package ddr1_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    typedef logic [3:0] state_t;

    localparam state_t ST_INIT     = 4'd0;
    localparam state_t ST_IDLE     = 4'd1;
    localparam state_t ST_PRE      = 4'd2;
    localparam state_t ST_PRE_WAIT = 4'd3;
    localparam state_t ST_ACT      = 4'd4;
    localparam state_t ST_ACT_WAIT = 4'd5;
    localparam state_t ST_CMD      = 4'd6;
    localparam state_t ST_WR_REC   = 4'd7;
    localparam state_t ST_RD_WAIT  = 4'd8;

    typedef enum logic [1:0] {
        HIT,
        CLOSED,
        CONFLICT
    } lookup_t;

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ddr1_bank_row_tracker.sv
// Open-row table for the four DDR1 banks with a combinational
// hit/closed/conflict lookup.
module ddr1_bank_row_tracker
    import ddr1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        open_en,
    input  logic        close_en,
    input  logic [1:0]  upd_bank,
    input  logic [12:0] upd_row,
    input  logic [1:0]  look_bank,
    input  logic [12:0] look_row,
    output lookup_t     result
);

    logic [3:0]  valid;
    logic [12:0] rows [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (open_en) begin
            valid[upd_bank] <= 1'b1;
        end else if (close_en) begin
            valid[upd_bank] <= 1'b0;
        end
    end

    // Row storage needs no reset; an entry is only trusted while valid.
    always_ff @(posedge clk) begin
        if (open_en) begin
            rows[upd_bank] <= upd_row;
        end
    end

    always_comb begin
        result = CLOSED;
        if (valid[look_bank]) begin
            result = (rows[look_bank] == look_row) ? HIT : CONFLICT;
        end
    end

endmodule

// File: rtl/ddr1_cmd_initiator.sv
// DDR1 host command initiator: one request at a time, PRE/ACT/RD/WR
// sequencing with NOP fill and registered pin outputs.
module ddr1_cmd_initiator
    import ddr1_pkg::*;
#(
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int T_WR   = 2,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_bank,
    input  logic [12:0] req_row,
    input  logic [9:0]  req_col,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  ba,
    output logic [12:0] addr,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    input  logic [15:0] dq_in
);

    localparam int TMAX = max4(T_RCD, T_RP, T_WR, RD_LAT);
    localparam int TW   = (TMAX > 7) ? $clog2(TMAX + 1) : 3;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_dec;
    logic          timer_one;
    logic [3:0]    cmd;

    logic          we_q;
    logic [1:0]    bank_q;
    logic [12:0]   row_q;
    logic [9:0]    col_q;
    logic [15:0]   wdata_q;

    logic          cur_we;
    logic [1:0]    cur_bank;
    logic [12:0]   cur_row;
    logic [9:0]    cur_col;
    logic [15:0]   cur_wdata;

    logic          idle;
    logic          entering;
    lookup_t       look;

    assign idle      = (state == ST_IDLE);
    assign req_ready = idle && !rst;
    assign entering  = (state_nx != state);
    assign timer_one = (timer == TW'(1));
    assign timer_dec = (timer == '0) ? '0 : timer - TW'(1);

    assign {cs_n, ras_n, cas_n, we_n} = cmd;

    // The first command is issued on the handshake edge itself, so the
    // live request fields are used there and the latched copy afterwards.
    always_comb begin
        cur_we    = we_q;
        cur_bank  = bank_q;
        cur_row   = row_q;
        cur_col   = col_q;
        cur_wdata = wdata_q;
        if (idle) begin
            cur_we    = req_we;
            cur_bank  = req_bank;
            cur_row   = req_row;
            cur_col   = req_col;
            cur_wdata = req_wdata;
        end
    end

    ddr1_bank_row_tracker u_tracker (
        .clk       (clk),
        .rst       (rst),
        .open_en   (entering && state_nx == ST_ACT),
        .close_en  (entering && state_nx == ST_PRE),
        .upd_bank  (cur_bank),
        .upd_row   (cur_row),
        .look_bank (req_bank),
        .look_row  (req_row),
        .result    (look)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_INIT: state_nx = ST_IDLE;
            ST_IDLE: begin
                if (req_valid) begin
                    case (look)
                        HIT:     state_nx = ST_CMD;
                        CLOSED:  state_nx = ST_ACT;
                        default: state_nx = ST_PRE;
                    endcase
                end
            end
            ST_PRE, ST_PRE_WAIT:
                state_nx = timer_one ? ST_ACT : ST_PRE_WAIT;
            ST_ACT, ST_ACT_WAIT:
                state_nx = timer_one ? ST_CMD : ST_ACT_WAIT;
            ST_CMD:
                state_nx = we_q ? ST_WR_REC : ST_RD_WAIT;
            ST_WR_REC, ST_RD_WAIT:
                state_nx = timer_one ? ST_IDLE : state;
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            timer     <= '0;
            cke       <= 1'b0;
            cmd       <= CMD_DESEL;
            ba        <= '0;
            addr      <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            we_q      <= 1'b0;
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_nx;
            cmd       <= CMD_NOP;
            dq_oe     <= 1'b0;
            rsp_valid <= 1'b0;
            if (state == ST_INIT) begin
                cke <= 1'b1;
            end
            if (idle && req_valid) begin
                we_q    <= req_we;
                bank_q  <= req_bank;
                row_q   <= req_row;
                col_q   <= req_col;
                wdata_q <= req_wdata;
            end
            // Timer counts across PRE->PRE_WAIT and ACT->ACT_WAIT.
            if (entering) begin
                case (state_nx)
                    ST_PRE:     timer <= TW'(T_RP);
                    ST_ACT:     timer <= TW'(T_RCD);
                    ST_WR_REC:  timer <= TW'(T_WR);
                    ST_RD_WAIT: timer <= TW'(RD_LAT);
                    default:    timer <= timer_dec;
                endcase
                case (state_nx)
                    ST_PRE: begin
                        cmd  <= CMD_PRE;
                        ba   <= cur_bank;
                        addr <= '0;
                    end
                    ST_ACT: begin
                        cmd  <= CMD_ACT;
                        ba   <= cur_bank;
                        addr <= cur_row;
                    end
                    ST_CMD: begin
                        cmd  <= cur_we ? CMD_WR : CMD_RD;
                        ba   <= cur_bank;
                        addr <= {3'b000, cur_col};
                        if (cur_we) begin
                            dq_oe  <= 1'b1;
                            dq_out <= cur_wdata;
                        end
                    end
                    default: ;
                endcase
            end else begin
                timer <= timer_dec;
            end
            if (state == ST_RD_WAIT && timer_one) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= dq_in;
            end
        end
    end

endmodule

// File: doc/ddr1_cmd_initiator.md
Name: ddr1_cmd_initiator

Overview:
- Host-side command initiator for the team's DDR1 device core. It drives the other end of the device's cmd/ba/addr/data pin interface.
- Accepts single-beat user read/write requests over a valid/ready handshake.
- Tracks the open row of each of the 4 banks. Issues PRE/ACT/RD/WR with NOP fill to meet programmable timing.
- Returns read data after the device's fixed read latency.

Parameters:
T_RCD, 2, cycles from ACT command cycle to RD/WR command cycle (min 1)
T_RP, 2, cycles from PRE command cycle to ACT command cycle (min 1)
T_WR, 2, cycles after WR command cycle before req_ready reasserts (min 1)
RD_LAT, 2, rising edges from device sampling RD to dq_in holding valid data (min 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready at a rising edge
req_we  in  1  1=write, 0=read
req_bank  in  2  target bank
req_row  in  13  target row
req_col  in  10  target column
req_wdata  in  16  write data
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_rdata  out  16  read data
cke  out  1  clock enable to device
cs_n, ras_n, cas_n, we_n  out  1 each  command pins
ba  out  2  bank address pins
addr  out  13  address pins
dq_out  out  16  write data to pads
dq_oe  out  1  pad output enable
dq_in  in  16  read data from pads

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- All pin-side outputs and rsp_* are registered.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP=0111, ACT=0011, RD=0101, WR=0100, PRE=0010, DESEL=1111.
  - Any cycle with no command outputs NOP.
- Reset values:
  - cke=0, command=DESEL, ba=0, addr=0, dq_out=0, dq_oe=0.
  - rsp_valid=0, rsp_rdata=0, req_ready=0.
  - Open-row table: all banks closed.
- States: INIT, IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CMD, WR_REC, RD_WAIT.
- INIT (first cycle after rst deasserts): cke<=1, go to IDLE. cke stays 1 until the next reset.
- IDLE: req_ready=1 (combinational from state, forced 0 while rst). On handshake at edge E, latch the request and classify it against the open-row table:
  - hit (bank open, same row) -> CMD
  - closed -> ACT
  - conflict (bank open, different row) -> PRE
- Pin-sampled timing relative to handshake edge E:
  - hit: RD/WR sampled at E+1.
  - closed: ACT at E+1, RD/WR at E+1+T_RCD.
  - conflict: PRE at E+1, ACT at E+1+T_RP, RD/WR at E+1+T_RP+T_RCD.
  - NOP in every gap cycle.
- Pin addressing:
  - ACT: ba=bank, addr=row; table marks bank open with that row.
  - PRE: ba=bank, addr[10]=0; table marks bank closed.
  - RD/WR: ba=bank, addr={3'b0, col}. addr[10]=0, so there is never auto-precharge; the row stays open.
- WR cycle: dq_oe=1 and dq_out=wdata in the same cycle the WR command is on the pins. dq_oe=0 in all other cycles. Then WR_REC holds NOP for T_WR cycles and returns to IDLE.
- RD: if the device samples RD at edge R, dq_in is captured at edge R+RD_LAT into rsp_rdata. rsp_valid=1 for exactly the following cycle. State returns to IDLE in that same cycle, so req_ready and rsp_valid rise together.
- One request in flight at a time. req_valid outside IDLE is ignored. The requester must hold request fields stable until the handshake.
- No refresh and no multi-bank interleave.
- Reset mid-operation: rst wins in any state.
  - Outputs go to their reset values and the table is cleared.
  - A pending read produces no rsp_valid.
  - A PRE/ACT already issued is not tracked; the next access to that bank re-ACTs.
- Timer: one down-counter, 3 bits wide minimum, sized to the max of the parameters. Loaded on state entry. Transition when it reaches 1.

Decomposition:
- Package ddr1_pkg holds:
  - command encoding constants (CMD_NOP/ACT/RD/WR/PRE/DESEL, 4 bits)
  - the state enum
  - the lookup-result enum (HIT/CLOSED/CONFLICT)
- Sub-module ddr1_bank_row_tracker:
  - 4-entry {valid, row[12:0]} table with a synchronous clear on rst
  - open/close update ports
  - combinational lookup returning the result enum for (bank,row)

Test Plan:
- Reset: rst high 3 cycles -> cke=0, cmd=DESEL, req_ready=0. First edge after release: cke=1. Next cycle: req_ready=1.
- Write, closed bank (bank=1,row=0x0A5,col=0x003,wdata=0xBEEF, T_RCD=2) -> ACT ba=1 addr=0x0A5 at E+1; NOP; WR ba=1 addr=0x003, dq_oe=1, dq_out=0xBEEF at E+3. req_ready returns after 2 NOP cycles.
- Read hit (bank=1,row=0x0A5,col=0x003), bench drives dq_in=0xBEEF at edge R+2 -> RD at E+1, no ACT, rsp_valid single pulse with rsp_rdata=0xBEEF.
- Row conflict (bank=1,row=0x0A6, read) -> PRE ba=1 at E+1, ACT addr=0x0A6 at E+3, RD at E+5. No spurious dq_oe.
- Loopback against the team's DDR1 device core: write 0x1234/0x5678 to banks 0/1 (different rows), then read both back -> data matches. Exactly one ACT per bank per row change.
- Reset between RD and capture -> no rsp_valid. A following read to the same row issues ACT first (table cleared).
